// File: rtl/conv_out_streamer_if.sv
// Handshake bundle between the conv core (master side) and the result streamer (slave side).
// DATA_W must match the DATA_W of the attached conv_out_streamer.
interface conv_out_streamer_if #(
   parameter int DATA_W = 24
);
   logic              start;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              data_validity;
   logic              img_end;
   logic              done;

   modport master (
      output start, in_data, in_valid, out_ready,
      input  in_ready, out_data, data_validity, img_end, done
   );

   modport slave (
      input  start, in_data, in_valid, out_ready,
      output in_ready, out_data, data_validity, img_end, done
   );
endinterface

// File: rtl/conv_out_streamer.sv
// Buffers conv accumulator results in a small FIFO and replays them as one raster-ordered frame,
// with optional ReLU on the way out, a row-end marker and a frame-done pulse.
module conv_out_streamer #(
   parameter int DATA_W     = 24,
   parameter int IMG_W      = 28,
   parameter int IMG_H      = 28,
   parameter int FIFO_DEPTH = 16,
   parameter int RELU_EN    = 1
) (
   input logic                clk,
   input logic                rst_n,
   conv_out_streamer_if.slave bus
);
   localparam int TOTAL = IMG_W * IMG_H;
   localparam int CNT_W = $clog2(TOTAL + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   localparam logic [CNT_W-1:0] TOTAL_C    = CNT_W'(TOTAL);
   localparam logic [CNT_W-1:0] COL_LAST_C = CNT_W'(IMG_W - 1);
   localparam logic [CNT_W-1:0] ROW_LAST_C = CNT_W'(IMG_H - 1);
   localparam logic [OCC_W-1:0] DEPTH_C    = OCC_W'(FIFO_DEPTH);

   logic [1:0]        state_reg, state_next;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [OCC_W-1:0]  count_reg, count_next;
   logic              full_reg, empty_reg;
   logic [CNT_W-1:0]  in_cnt_reg, col_reg, row_reg;
   logic [DATA_W-1:0] out_data_reg;
   logic              valid_reg, img_end_reg, done_reg;
   logic [DATA_W-1:0] rd_word, relu_word;
   logic              in_ready_c, push, pop, last_pop;

   // Input side stops at exactly one frame's worth of words, even if the core keeps offering.
   assign in_ready_c = (state_reg == ST_STREAM) && !full_reg && (in_cnt_reg < TOTAL_C);
   assign push       = bus.in_valid && in_ready_c;
   assign pop        = (state_reg == ST_STREAM) && !empty_reg && bus.out_ready;
   assign last_pop   = pop && (col_reg == COL_LAST_C) && (row_reg == ROW_LAST_C);

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (bus.start) state_next = ST_STREAM;
         ST_STREAM: if (last_pop) state_next = ST_DONE;
         ST_DONE:   state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // Storage carries no reset so it maps onto distributed/block RAM.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= bus.in_data;
   end

   assign rd_word = mem[rd_ptr_reg];

   generate
      if (RELU_EN != 0) begin : g_relu
         assign relu_word = rd_word[DATA_W-1] ? '0 : rd_word;
      end else begin : g_pass
         assign relu_word = rd_word;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         full_reg     <= 1'b0;
         empty_reg    <= 1'b1;
         in_cnt_reg   <= '0;
         col_reg      <= '0;
         row_reg      <= '0;
         out_data_reg <= '0;
         valid_reg    <= 1'b0;
         img_end_reg  <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         valid_reg   <= pop;
         img_end_reg <= pop && (col_reg == COL_LAST_C);
         done_reg    <= (state_reg == ST_DONE);
         if (pop) out_data_reg <= relu_word;

         if (state_reg == ST_IDLE) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
            in_cnt_reg <= '0;
            col_reg    <= '0;
            row_reg    <= '0;
         end else begin
            if (push) begin
               wr_ptr_reg <= wr_ptr_reg + 1'b1;
               in_cnt_reg <= in_cnt_reg + 1'b1;
            end
            if (pop) begin
               rd_ptr_reg <= rd_ptr_reg + 1'b1;
               if (col_reg == COL_LAST_C) begin
                  col_reg <= '0;
                  row_reg <= row_reg + 1'b1;
               end else begin
                  col_reg <= col_reg + 1'b1;
               end
            end
            // Flags follow the next occupancy so they are clean registers, not decode of count.
            count_reg <= count_next;
            full_reg  <= (count_next == DEPTH_C);
            empty_reg <= (count_next == '0);
         end
      end
   end

   assign bus.in_ready      = in_ready_c;
   assign bus.out_data      = out_data_reg;
   assign bus.data_validity = valid_reg;
   assign bus.img_end       = img_end_reg;
   assign bus.done          = done_reg;
endmodule

// File: tb/tb_conv_out_streamer.sv
// Directed bench for conv_out_streamer on a 4x2 frame with a 4-deep FIFO; a ReLU and a
// pass-through instance share stimulus and are checked against a queue-based scoreboard.
module tb_conv_out_streamer;
   localparam int W = 4;
   localparam int H = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   conv_out_streamer_if #(.DATA_W(24)) u_if ();
   conv_out_streamer_if #(.DATA_W(24)) n_if ();

   assign n_if.start     = u_if.start;
   assign n_if.in_data   = u_if.in_data;
   assign n_if.in_valid  = u_if.in_valid;
   assign n_if.out_ready = u_if.out_ready;

   conv_out_streamer #(
      .DATA_W(24), .IMG_W(W), .IMG_H(H), .FIFO_DEPTH(4), .RELU_EN(1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   conv_out_streamer #(
      .DATA_W(24), .IMG_W(W), .IMG_H(H), .FIFO_DEPTH(4), .RELU_EN(0)
   ) dut_nr (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (n_if)
   );

   typedef struct packed {
      logic [23:0] d;
      logic [23:0] dn;
      logic        e;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_cnt = 0;
   int   strobe_cnt = 0;
   int   done_cnt = 0;
   int   first_acc_cyc = -1;
   int   first_strobe_cyc = -1;
   int   last_strobe_cyc = -100;

   function automatic logic [23:0] relu(input logic [23:0] d);
      return d[23] ? 24'h0 : d;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Scoreboard: expectations are queued on acceptance and retired on each output strobe.
   always @(negedge clk) begin
      if (rst_n) begin
         check("img_end_gated", 32'(u_if.img_end & ~u_if.data_validity), 0);
         if (u_if.data_validity) begin
            check("strobe_has_expect", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("out_data", 32'(u_if.out_data), 32'(mon_e.d));
               check("img_end", 32'(u_if.img_end), 32'(mon_e.e));
               check("out_data_norelu", 32'(n_if.out_data), 32'(mon_e.dn));
            end
            if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
            last_strobe_cyc = cyc;
            strobe_cnt++;
         end
         if (u_if.done) begin
            done_cnt++;
            check("done_latency", cyc - last_strobe_cyc, 1);
            check("done_queue_empty", exp_q.size(), 0);
         end
         if (u_if.in_valid && u_if.in_ready) begin
            exp_q.push_back('{d: relu(u_if.in_data), dn: u_if.in_data,
                              e: ((acc_cnt % W) == W - 1)});
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            acc_cnt++;
         end
      end
   end

   task automatic new_frame();
      acc_cnt          = 0;
      strobe_cnt       = 0;
      done_cnt         = 0;
      first_acc_cyc    = -1;
      first_strobe_cyc = -1;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1;
      u_if.start = 1'b1;
      @(posedge clk); #1;
      u_if.start = 1'b0;
   endtask

   task automatic send(input logic [23:0] d);
      logic ok;
      ok = 1'b0;
      u_if.in_data  = d;
      u_if.in_valid = 1'b1;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         if (u_if.in_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      u_if.in_valid = 1'b0;
      check("send_accepted", 32'(ok), 1);
   endtask

   task automatic wait_done(input string tag);
      for (int t = 0; t < 300 && done_cnt == 0; t++) begin
         @(posedge clk); #1;
      end
      repeat (4) @(posedge clk);
      #1;
      check({tag, "_done_once"}, done_cnt, 1);
      check({tag, "_strobes"}, strobe_cnt, W * H);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [23:0] relu_vec [8];
      logic        started;
      logic        ready_checked;

      u_if.start     = 1'b0;
      u_if.in_data   = '0;
      u_if.in_valid  = 1'b0;
      u_if.out_ready = 1'b1;

      // Power-on reset
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_data", 32'(u_if.out_data), 0);
      check("rst_valid", 32'(u_if.data_validity), 0);
      check("rst_img_end", 32'(u_if.img_end), 0);
      check("rst_done", 32'(u_if.done), 0);
      check("rst_in_ready", 32'(u_if.in_ready), 0);
      rst_n = 1'b1;
      u_if.in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle_in_ready", 32'(u_if.in_ready), 0);
      u_if.in_valid = 1'b0;
      check("idle_no_strobe", strobe_cnt, 0);

      // Basic frame 1..8, back-to-back pushes
      new_frame();
      pulse_start();
      for (int k = 1; k <= 8; k++) send(24'(k));
      wait_done("basic");
      check("first_latency", first_strobe_cyc - first_acc_cyc, 2);

      // ReLU boundary values
      relu_vec = '{24'hFFFFF0, 24'h000010, 24'h800000, 24'h7FFFFF,
                   24'h000001, 24'hFFFFFF, 24'h123456, 24'h800001};
      new_frame();
      pulse_start();
      for (int k = 0; k < 8; k++) send(relu_vec[k]);
      wait_done("relu");

      // Backpressure: output stalled, FIFO fills to depth
      new_frame();
      u_if.out_ready = 1'b0;
      pulse_start();
      u_if.in_valid = 1'b1;
      u_if.in_data  = 24'h100;
      repeat (10) begin
         @(posedge clk); #1;
         u_if.in_data = 24'(32'h100 + acc_cnt);
      end
      check("bp_accepted", acc_cnt, 4);
      check("bp_in_ready", 32'(u_if.in_ready), 0);
      check("bp_no_strobe", strobe_cnt, 0);
      u_if.out_ready = 1'b1;
      for (int t = 0; t < 60 && acc_cnt < 8; t++) begin
         @(posedge clk); #1;
         u_if.in_data = 24'(32'h100 + acc_cnt);
      end
      u_if.in_valid = 1'b0;
      check("bp_total_accepted", acc_cnt, 8);
      wait_done("bp");

      // Over-supply, with a stray start mid-stream
      new_frame();
      started       = 1'b0;
      ready_checked = 1'b0;
      pulse_start();
      u_if.in_valid = 1'b1;
      u_if.in_data  = 24'h200;
      for (int t = 0; t < 60 && done_cnt == 0; t++) begin
         @(posedge clk); #1;
         u_if.in_data = 24'(32'h200 + acc_cnt);
         u_if.start   = 1'b0;
         if (acc_cnt >= 3 && !started) begin
            u_if.start = 1'b1;
            started    = 1'b1;
         end
         if (acc_cnt == 8 && !ready_checked) begin
            check("ovr_in_ready_after_8", 32'(u_if.in_ready), 0);
            ready_checked = 1'b1;
         end
      end
      u_if.start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      u_if.in_valid = 1'b0;
      check("ovr_accepted", acc_cnt, 8);
      check("ovr_done_once", done_cnt, 1);
      check("ovr_strobes", strobe_cnt, 8);

      // Reset in the middle of a frame
      new_frame();
      pulse_start();
      send(24'h5A);
      send(24'h11);
      send(24'h22);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_data", 32'(u_if.out_data), 0);
      check("midrst_valid", 32'(u_if.data_validity), 0);
      check("midrst_img_end", 32'(u_if.img_end), 0);
      check("midrst_done", 32'(u_if.done), 0);
      check("midrst_in_ready", 32'(u_if.in_ready), 0);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      new_frame();
      u_if.in_valid = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("postrst_in_ready", 32'(u_if.in_ready), 0);
      u_if.in_valid = 1'b0;
      check("postrst_no_strobe", strobe_cnt, 0);
      check("postrst_no_done", done_cnt, 0);

      // Recovery frame after reset
      new_frame();
      pulse_start();
      for (int k = 0; k < 8; k++) send(24'(32'hA0 + k));
      wait_done("recover");
      check("recover_latency", first_strobe_cyc - first_acc_cyc, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
